seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller feeding a 4-bit-to-7-segment decoder.
// Each digit slot is BLANK (all anodes off, anti-ghosting) followed by DRIVE
// (one anode low). The displayed value lives in a shadow register that only
// changes when the scan index wraps to 0, so a frame never mixes two values.
// New values arrive through a valid/ready port into a one-entry pending buffer.
//
// Handshake: a transfer happens on a rising clk_in edge where
// val_valid_in & val_ready_out are both 1. val_ready_out is ~pending_full,
// so it drops the cycle after a transfer and rises again the cycle after the
// pending value has been committed into the shadow register. The source must
// hold val_in stable while val_valid_in is high and val_ready_out is low.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [4*NUM_DIGITS-1:0]       val_in,
    input  logic                          val_valid_in,
    output logic                          val_ready_out,
    input  logic [NUM_DIGITS-1:0]         en_mask_in,
    input  logic                          lz_blank_in,
    output logic [3:0]                    digit_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_out
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Scan FSM registers
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;

    // Value path registers
    logic [VAL_W-1:0]   r_shadow;
    logic [VAL_W-1:0]   r_pending;
    logic               r_pending_full;

    // Registered outputs
    logic [3:0]            r_digit;
    logic [NUM_DIGITS-1:0] r_an;

    // Next-state wires
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_adv;
    logic               w_wrap;

    logic               w_accept;
    logic               w_commit;
    logic [VAL_W-1:0]   w_shadow_nxt;
    logic [VAL_W-1:0]   w_pending_nxt;
    logic               w_pending_full_nxt;

    logic [3:0]            w_nib;
    logic [3:0]            w_digit_nxt;
    logic                  w_run;
    logic [NUM_DIGITS-1:0] w_sup;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    // Scan FSM: next state, cycle counter and digit index
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_adv       = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == DIGIT_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_adv       = 1'b1;
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : (r_idx + 1'b1);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
        w_wrap = w_adv && (r_idx == IDX_LAST);
    end

    // Load port and frame-boundary commit; a commit always takes the old pending contents
    always_comb begin
        w_accept           = val_valid_in & ~r_pending_full;
        w_commit           = w_wrap & r_pending_full;
        w_shadow_nxt       = w_commit ? r_pending : r_shadow;
        w_pending_nxt      = w_accept ? val_in : r_pending;
        w_pending_full_nxt = r_pending_full;
        if (w_accept) begin
            w_pending_full_nxt = 1'b1;
        end else if (w_commit) begin
            w_pending_full_nxt = 1'b0;
        end
    end

    // Leading-zero flags: digit k is suppressible when it and every digit above it are zero
    always_comb begin
        w_sup = '0;
        w_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run    = w_run & (w_shadow_nxt[4*k +: 4] == 4'h0);
            w_sup[k] = w_run & (k != 0);
        end
    end

    // Nibble of the upcoming digit, taken from the (possibly just committed) shadow value
    always_comb begin
        w_nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == IDX_W'(k)) begin
                w_nib = w_shadow_nxt[4*k +: 4];
            end
        end
        w_digit_nxt = w_adv ? w_nib : r_digit;
    end

    // Anode pattern for the next cycle; enable mask and suppression are sampled live
    always_comb begin
        w_an_nxt = '1;
        if (w_state_nxt == ST_DRIVE && en_mask_in[w_idx_nxt] &&
            !(lz_blank_in && w_sup[w_idx_nxt])) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Shadow / pending value registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shadow       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
        end else begin
            r_shadow       <= w_shadow_nxt;
            r_pending      <= w_pending_nxt;
            r_pending_full <= w_pending_full_nxt;
        end
    end

    // Display output registers; reset blanks every anode immediately
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_digit <= '0;
            r_an    <= '1;
        end else begin
            r_digit <= w_digit_nxt;
            r_an    <= w_an_nxt;
        end
    end

    assign digit_out     = r_digit;
    assign an_out        = r_an;
    assign digit_idx_out = r_idx;
    assign val_ready_out = ~r_pending_full;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4 drive cycles, 1 blank cycle.
// Sample n counts clock edges since reset release; sample n is taken at the
// falling edge after edge n. Slot = 5 samples (phase 0 blank, 1..4 drive),
// frame = 20 samples, commits land on samples that are multiples of 20.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DC    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = ND * SLOT;

    logic        clk_in;
    logic        rst_n_in;
    logic [15:0] val_in;
    logic        val_valid_in;
    logic        val_ready_out;
    logic [3:0]  en_mask_in;
    logic        lz_blank_in;
    logic [3:0]  digit_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx_out;

    int checks;
    int errors;
    int n;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .val_in       (val_in),
        .val_valid_in (val_valid_in),
        .val_ready_out(val_ready_out),
        .en_mask_in   (en_mask_in),
        .lz_blank_in  (lz_blank_in),
        .digit_out    (digit_out),
        .an_out       (an_out),
        .digit_idx_out(digit_idx_out)
    );

    // clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // expected anode pattern for a shown value at sample n
    function automatic logic [3:0] exp_an(input logic [15:0] v, input int s,
                                          input logic [3:0] m, input logic lz);
        int  ph;
        int  idx;
        logic sup;
        ph     = s % SLOT;
        idx    = (s / SLOT) % ND;
        exp_an = 4'hF;
        if (ph >= BC) begin
            sup = lz && (idx != 0) && ((v >> (4 * idx)) == 16'h0000);
            if (m[idx] && !sup) exp_an[idx] = 1'b0;
        end
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] v, input int s);
        int idx;
        idx = (s / SLOT) % ND;
        exp_digit = v[4*idx +: 4];
    endfunction

    function automatic logic [1:0] exp_idx(input int s);
        exp_idx = 2'((s / SLOT) % ND);
    endfunction

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        n++;
    endtask

    task automatic test_reset();
        rst_n_in     = 1'b0;
        val_in       = 16'h0;
        val_valid_in = 1'b0;
        en_mask_in   = 4'hF;
        lz_blank_in  = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++; if (an_out !== 4'hF) begin errors++; $display("FAIL reset_an got %b exp %b", an_out, 4'hF); end
        checks++; if (digit_out !== 4'h0) begin errors++; $display("FAIL reset_digit got %h exp %h", digit_out, 4'h0); end
        checks++; if (digit_idx_out !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", digit_idx_out); end
        checks++; if (val_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", val_ready_out); end
        rst_n_in = 1'b1;
        n = 0;
    endtask

    // frame 0 with value 0: 1111 blank then 1110 for four cycles, then idx 1..3
    task automatic test_idle();
        logic [15:0] v;
        for (int k = 0; k < FRAME; k++) begin
            v = 16'h0000;
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL idle_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL idle_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (digit_idx_out !== exp_idx(n)) begin errors++; $display("FAIL idle_idx n=%0d got %0d exp %0d", n, digit_idx_out, exp_idx(n)); end
            checks++; if (val_ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready n=%0d got %b exp 1", n, val_ready_out); end
            checks++; if ($countones(~an_out) > 1) begin errors++; $display("FAIL idle_onehot n=%0d got %b exp at most one low", n, an_out); end
            step();
        end
    endtask

    // load 0x1A2B at sample 23; frame 20..39 still shows 0, frame 40..59 shows 1A2B
    task automatic test_load_mid();
        logic [15:0] v;
        logic        r;
        for (int k = 0; k < 2 * FRAME; k++) begin
            v = (n < 40) ? 16'h0000 : 16'h1A2B;
            r = !(n >= 24 && n <= 39);
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL load_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL load_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (digit_idx_out !== exp_idx(n)) begin errors++; $display("FAIL load_idx n=%0d got %0d exp %0d", n, digit_idx_out, exp_idx(n)); end
            checks++; if (val_ready_out !== r) begin errors++; $display("FAIL load_ready n=%0d got %b exp %b", n, val_ready_out, r); end
            checks++; if ($countones(~an_out) > 1) begin errors++; $display("FAIL load_onehot n=%0d got %b exp at most one low", n, an_out); end
            if (n == 23) begin val_in = 16'h1A2B; val_valid_in = 1'b1; end
            if (n == 24) val_valid_in = 1'b0;
            step();
        end
    endtask

    // 0x1111 accepted at edge 61, 0x2222 stalls until edge 81
    task automatic test_back_to_back();
        logic [15:0] v;
        logic        r;
        for (int k = 0; k < 3 * FRAME; k++) begin
            v = (n < 80) ? 16'h1A2B : ((n < 100) ? 16'h1111 : 16'h2222);
            r = !((n >= 61 && n <= 79) || (n >= 81 && n <= 99));
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL b2b_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL b2b_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (digit_idx_out !== exp_idx(n)) begin errors++; $display("FAIL b2b_idx n=%0d got %0d exp %0d", n, digit_idx_out, exp_idx(n)); end
            checks++; if (val_ready_out !== r) begin errors++; $display("FAIL b2b_ready n=%0d got %b exp %b", n, val_ready_out, r); end
            checks++; if ($countones(~an_out) > 1) begin errors++; $display("FAIL b2b_onehot n=%0d got %b exp at most one low", n, an_out); end
            if (n == 60) begin val_in = 16'h1111; val_valid_in = 1'b1; end
            if (n == 61) val_in = 16'h2222;
            if (n == 81) val_valid_in = 1'b0;
            step();
        end
    endtask

    // 0x0050 and 0x0000 with suppression on; also queues 0x4321 for the mask test
    task automatic test_leading_zero();
        logic [15:0] v;
        logic        r;
        for (int k = 0; k < 3 * FRAME; k++) begin
            v = (n < 140) ? 16'h2222 : ((n < 160) ? 16'h0050 : 16'h0000);
            r = !((n >= 121 && n <= 139) || (n >= 141 && n <= 159) || (n >= 161 && n <= 179));
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL lz_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL lz_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (digit_idx_out !== exp_idx(n)) begin errors++; $display("FAIL lz_idx n=%0d got %0d exp %0d", n, digit_idx_out, exp_idx(n)); end
            checks++; if (val_ready_out !== r) begin errors++; $display("FAIL lz_ready n=%0d got %b exp %b", n, val_ready_out, r); end
            checks++; if ($countones(~an_out) > 1) begin errors++; $display("FAIL lz_onehot n=%0d got %b exp at most one low", n, an_out); end
            if (n == 120) begin val_in = 16'h0050; val_valid_in = 1'b1; lz_blank_in = 1'b1; end
            if (n == 140) begin val_in = 16'h0000; val_valid_in = 1'b1; end
            if (n == 160) begin val_in = 16'h4321; val_valid_in = 1'b1; end
            if (n == 121 || n == 141 || n == 161) val_valid_in = 1'b0;
            if (n == 179) begin en_mask_in = 4'b1010; lz_blank_in = 1'b0; end
            step();
        end
    endtask

    // mask 1010 on 0x4321: only idx 1 and 3 drive
    task automatic test_mask();
        logic [15:0] v;
        for (int k = 0; k < FRAME; k++) begin
            v = 16'h4321;
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL mask_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL mask_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (digit_idx_out !== exp_idx(n)) begin errors++; $display("FAIL mask_idx n=%0d got %0d exp %0d", n, digit_idx_out, exp_idx(n)); end
            checks++; if (val_ready_out !== 1'b1) begin errors++; $display("FAIL mask_ready n=%0d got %b exp 1", n, val_ready_out); end
            checks++; if ($countones(~an_out) > 1) begin errors++; $display("FAIL mask_onehot n=%0d got %b exp at most one low", n, an_out); end
            if (n == 199) en_mask_in = 4'hF;
            step();
        end
    endtask

    // queue 0x7777, then reset during DRIVE of idx 2; nothing may survive
    task automatic test_reset_mid();
        logic [15:0] v;
        logic        r;
        while (n <= 212) begin
            v = 16'h4321;
            r = !(n >= 206);
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL rmid_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL rmid_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (val_ready_out !== r) begin errors++; $display("FAIL rmid_ready n=%0d got %b exp %b", n, val_ready_out, r); end
            if (n == 205) begin val_in = 16'h7777; val_valid_in = 1'b1; end
            if (n == 206) val_valid_in = 1'b0;
            if (n == 212) break;
            step();
        end
        rst_n_in = 1'b0;
        #1;
        checks++; if (an_out !== 4'hF) begin errors++; $display("FAIL rmid_async_an got %b exp %b", an_out, 4'hF); end
        checks++; if (digit_idx_out !== 2'd0) begin errors++; $display("FAIL rmid_async_idx got %0d exp 0", digit_idx_out); end
        checks++; if (digit_out !== 4'h0) begin errors++; $display("FAIL rmid_async_digit got %h exp 0", digit_out); end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        n = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            v = 16'h0000;
            checks++; if (an_out !== exp_an(v, n, en_mask_in, lz_blank_in)) begin errors++; $display("FAIL post_an n=%0d got %b exp %b", n, an_out, exp_an(v, n, en_mask_in, lz_blank_in)); end
            checks++; if (digit_out !== exp_digit(v, n)) begin errors++; $display("FAIL post_digit n=%0d got %h exp %h", n, digit_out, exp_digit(v, n)); end
            checks++; if (digit_idx_out !== exp_idx(n)) begin errors++; $display("FAIL post_idx n=%0d got %0d exp %0d", n, digit_idx_out, exp_idx(n)); end
            checks++; if (val_ready_out !== 1'b1) begin errors++; $display("FAIL post_ready n=%0d got %b exp 1", n, val_ready_out); end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n      = 0;
        test_reset();
        test_idle();
        test_load_mid();
        test_back_to_back();
        test_leading_zero();
        test_mask();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
